// File: rtl/keyarb.sv
// keyarb: N-channel keyed request arbiter issuing round-robin to the ALU and waiting for the key echo.
// Optional macro KEYARB_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT cycles.
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 4
`endif
`ifndef KEY_SIZE
`define KEY_SIZE 8
`endif
`ifndef OPERAND_SIZE
`define OPERAND_SIZE 32
`endif

module keyarb #(
    parameter int unsigned NINPUTS = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NINPUTS*`OPCODE_SIZE-1:0]    op_i,
    input  logic [NINPUTS*`KEY_SIZE-1:0]       key_i,
    input  logic [NINPUTS*`OPERAND_SIZE-1:0]   A_i,
    input  logic [NINPUTS*`OPERAND_SIZE-1:0]   B_i,
    input  logic [`KEY_SIZE-1:0]               keyback_i,
    output logic [`OPCODE_SIZE-1:0]            op_o,
    output logic [`KEY_SIZE-1:0]               key_o,
    output logic [`OPERAND_SIZE-1:0]           A_o,
    output logic [`OPERAND_SIZE-1:0]           B_o,
    output logic                               valid_o,
    output logic [NINPUTS-1:0]                 grant_o,
    output logic [NINPUTS-1:0]                 done_o,
    output logic [NINPUTS-1:0]                 overrun_o,
    output logic                               timeout_o
);
    localparam int unsigned OW = `OPCODE_SIZE;
    localparam int unsigned KW = `KEY_SIZE;
    localparam int unsigned DW = `OPERAND_SIZE;
    localparam int unsigned RW = (NINPUTS > 1) ? $clog2(NINPUTS) : 1;

    if (NINPUTS == 0) begin : g_bad_ninputs
        $fatal(1, "keyarb: NINPUTS must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $fatal(1, "keyarb: TIMEOUT must be at least 1");
    end

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e                     state_q, state_d;
    logic [NINPUTS-1:0][OW-1:0] slot_op_q;
    logic [NINPUTS-1:0][DW-1:0] slot_a_q, slot_b_q;
    logic [NINPUTS-1:0][KW-1:0] key_buff_q;
    logic [NINPUTS-1:0]         pending_q, overrun_q, chg, issue_oh;
    logic [RW-1:0]              rr_q, rr_d, pick_idx;
    logic                       pick_found;
    logic [OW-1:0]              op_q, op_d;
    logic [KW-1:0]              key_q, key_d;
    logic [DW-1:0]              a_q, a_d, b_q, b_d;
    logic                       valid_q, valid_d;
    logic [NINPUTS-1:0]         grant_q, grant_d, done_q, done_d;

`ifdef KEYARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
`endif

    always_comb begin
        chg = '0;
        for (int unsigned i = 0; i < NINPUTS; i++) begin
            chg[i] = (key_i[i*KW +: KW] != key_buff_q[i]);
        end
    end

    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= NINPUTS; k++) begin
            idx = (32'(rr_q) + k) % NINPUTS;
            if (!pick_found && pending_q[RW'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = RW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        op_d     = op_q;
        key_d    = key_q;
        a_d      = a_q;
        b_d      = b_q;
        valid_d  = 1'b0;
        grant_d  = grant_q;
        done_d   = '0;
        issue_oh = '0;
`ifdef KEYARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    for (int unsigned j = 0; j < NINPUTS; j++) begin
                        issue_oh[j] = (RW'(j) == pick_idx);
                    end
                    op_d    = slot_op_q[pick_idx];
                    key_d   = key_buff_q[pick_idx];
                    a_d     = slot_a_q[pick_idx];
                    b_d     = slot_b_q[pick_idx];
                    valid_d = 1'b1;
                    grant_d = issue_oh;
                    rr_d    = pick_idx;
                    state_d = S_WAIT;
`ifdef KEYARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (keyback_i == key_q) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    state_d = S_IDLE;
                end
`ifdef KEYARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            slot_op_q  <= '0;
            slot_a_q   <= '0;
            slot_b_q   <= '0;
            key_buff_q <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
            rr_q       <= '0;
            op_q       <= '0;
            key_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            valid_q    <= 1'b0;
            grant_q    <= '0;
            done_q     <= '0;
`ifdef KEYARB_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            op_q      <= op_d;
            key_q     <= key_d;
            a_q       <= a_d;
            b_q       <= b_d;
            valid_q   <= valid_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            pending_q <= (pending_q & ~issue_oh) | chg;
            // A slot issued on this edge is read out before the recapture, so no data is lost there
            overrun_q <= overrun_q | (chg & pending_q & ~issue_oh);
            for (int unsigned i = 0; i < NINPUTS; i++) begin
                if (chg[i]) begin
                    slot_op_q[i]  <= op_i[i*OW +: OW];
                    slot_a_q[i]   <= A_i[i*DW +: DW];
                    slot_b_q[i]   <= B_i[i*DW +: DW];
                    key_buff_q[i] <= key_i[i*KW +: KW];
                end
            end
`ifdef KEYARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign op_o      = op_q;
    assign key_o     = key_q;
    assign A_o       = a_q;
    assign B_o       = b_q;
    assign valid_o   = valid_q;
    assign grant_o   = grant_q;
    assign done_o    = done_q;
    assign overrun_o = overrun_q;
`ifdef KEYARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
